program_loader: RTL and testbench

Boot-time program loader that writes a byte stream into the core's instruction/data memory. It is the writer side of the memory the core fetches from. It accepts a length-prefixed, checksummed byte stream over a valid/ready handshake, packs bytes little-endian into words, and issues full-word writes on one memory write port. While loading it holds the core in reset, and it releases the core only after a clean checksum.

---
 rtl/program_loader_pkg.sv | 17 +
 rtl/loader_byte_packer.sv | 42 ++++
 rtl/program_loader.sv | 128 ++++++++++++
 tb/tb_program_loader.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package program_loader_pkg;

  localparam int unsigned LenWidth = 16;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLenLo = 3'd1,
    StLenHi = 3'd2,
    StData  = 3'd3,
    StWrite = 3'd4,
    StCheck = 3'd5,
    StDone  = 3'd6,
    StErr   = 3'd7
  } state_e;

endpackage

// File: rtl/loader_byte_packer.sv
// Packs payload bytes little-endian into a word and keeps the running XOR checksum.
module loader_byte_packer #(
  parameter int unsigned word_width = 32,
  parameter int unsigned WE_width   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  output logic [word_width-1:0] word_o,
  output logic [7:0]            checksum_o,
  output logic                  word_done_o
);

  localparam int unsigned IdxW = (WE_width > 1) ? $clog2(WE_width) : 1;

  logic [IdxW-1:0]       idx_q;
  logic [word_width-1:0] word_q;
  logic [7:0]            chk_q;

  assign word_done_o = byte_valid_i && (idx_q == IdxW'(WE_width - 1));
  assign word_o      = word_q;
  assign checksum_o  = chk_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q  <= '0;
      word_q <= '0;
      chk_q  <= '0;
    end else if (clear_i) begin
      idx_q  <= '0;
      word_q <= '0;
      chk_q  <= '0;
    end else if (byte_valid_i) begin
      word_q[{idx_q, 3'b000} +: 8] <= byte_i;
      chk_q                        <= chk_q ^ byte_i;
      idx_q                        <= word_done_o ? '0 : idx_q + IdxW'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed, checksummed byte stream and writes it to memory
// word by word, holding the core in reset until a load completes with a good checksum.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned word_width    = 32,
  parameter int unsigned address_width = 12,
  parameter int unsigned WE_width      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic [address_width-3:0] mem_A,
  output logic [word_width-1:0]    mem_W,
  output logic [WE_width-1:0]      mem_WE,
  output logic                     core_rst,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam int unsigned WordAddrW = address_width - 2;
  // One extra bit so a full image (2^WordAddrW words) does not wrap the counter.
  localparam int unsigned CntW      = address_width - 1;
  localparam int unsigned MaxWords  = 1 << WordAddrW;

  state_e                state_q, state_d;
  logic [CntW-1:0]       addr_q, addr_d, addr_inc;
  logic [LenWidth-1:0]   len_q, len_d, len_rx;
  logic [7:0]            len_lo_q, len_lo_d;
  logic                  transfer, clear, byte_valid, word_done;
  logic [7:0]            checksum;
  logic [word_width-1:0] word;

  assign transfer   = rx_valid & rx_ready;
  assign byte_valid = transfer && (state_q == StData);
  assign len_rx     = {rx_data, len_lo_q};
  assign addr_inc   = addr_q + CntW'(1);

  loader_byte_packer #(
    .word_width (word_width),
    .WE_width   (WE_width)
  ) u_packer (
    .clk_i        (clk),
    .rst_i        (rst),
    .clear_i      (clear),
    .byte_valid_i (byte_valid),
    .byte_i       (rx_data),
    .word_o       (word),
    .checksum_o   (checksum),
    .word_done_o  (word_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      len_q    <= '0;
      len_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      len_lo_q <= len_lo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    len_lo_d = len_lo_q;
    clear    = 1'b0;
    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StLenLo;
          addr_d  = '0;
          clear   = 1'b1;
        end
      end
      StLenLo: begin
        if (transfer) begin
          len_lo_d = rx_data;
          state_d  = StLenHi;
        end
      end
      StLenHi: begin
        if (transfer) begin
          len_d = len_rx;
          if (32'(len_rx) > MaxWords) begin
            state_d = StErr;
          end else if (len_rx == '0) begin
            state_d = StCheck;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (word_done) state_d = StWrite;
      end
      StWrite: begin
        addr_d  = addr_inc;
        state_d = (32'(addr_inc) == 32'(len_q)) ? StCheck : StData;
      end
      StCheck: begin
        if (transfer) state_d = (rx_data == checksum) ? StDone : StErr;
      end
      default: state_d = StIdle;
    endcase
  end

  // All outputs decode registered state, so an asynchronous reset clears them at once.
  assign rx_ready = (state_q == StLenLo) || (state_q == StLenHi) ||
                    (state_q == StData)  || (state_q == StCheck);
  assign busy     = rx_ready || (state_q == StWrite);
  assign core_rst = busy || (state_q == StErr);
  assign done     = (state_q == StDone);
  assign error    = (state_q == StErr);
  assign mem_WE   = (state_q == StWrite) ? '1 : '0;
  assign mem_A    = addr_q[WordAddrW-1:0];
  assign mem_W    = word;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: good/bad checksum, empty and oversize images,
// full image, gapped stream and mid-load reset.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [9:0]  mem_A;
  logic [31:0] mem_W;
  logic [3:0]  mem_WE;
  logic        core_rst, busy, done, error;

  int total = 0;
  int bad = 0;

  logic [9:0]  wa_q[$];
  logic [31:0] ww_q[$];
  logic [3:0]  wwe_q[$];
  int          rdy_viol = 0;
  logic [7:0]  tx_q[$];

  program_loader #(
    .word_width    (32),
    .address_width (12),
    .WE_width      (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .mem_A    (mem_A),
    .mem_W    (mem_W),
    .mem_WE   (mem_WE),
    .core_rst (core_rst),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  // Record every write cycle; while busy, rx_ready must be low exactly when writing.
  always @(negedge clk) begin
    if (mem_WE !== 4'h0) begin
      wa_q.push_back(mem_A);
      ww_q.push_back(mem_W);
      wwe_q.push_back(mem_WE);
    end
    if (busy === 1'b1 && rx_ready === (mem_WE !== 4'h0)) rdy_viol++;
  end

  function automatic logic [7:0] img_byte(input int j);
    return 8'(j * 37 + 11);
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget;
    if (gaps) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    budget   = 200;
    while (rx_ready !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      total++;
      bad++;
      $display("FAIL handshake_timeout: rx_ready=%b required 1", rx_ready);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_all(input bit gaps);
    foreach (tx_q[i]) send_byte(tx_q[i], gaps);
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({rx_ready, busy, core_rst, done, error} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b required 00000", {rx_ready, busy, core_rst, done, error});
    end
    total++;
    if ({mem_WE, mem_A, mem_W} !== 46'h0) begin
      bad++;
      $display("FAIL reset_mem: WE=%h A=%h W=%h required 0", mem_WE, mem_A, mem_W);
    end
    @(negedge clk);
    rst = 1'b0;
    pulse_start();
    total++;
    if ({busy, core_rst, rx_ready, done, error} !== 5'b11100) begin
      bad++;
      $display("FAIL start_latency: got %b required 11100", {busy, core_rst, rx_ready, done, error});
    end
  endtask

  task automatic test_good();
    int base = wa_q.size();
    tx_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    foreach (tx_q[i]) begin
      send_byte(tx_q[i], 1'b0);
      if (i == 5) begin
        total++;
        if (mem_WE !== 4'hF || mem_A !== 10'h0 || mem_W !== 32'h0000_0013 || rx_ready !== 1'b0) begin
          bad++;
          $display("FAIL first_write_timing: WE=%h A=%h W=%h rdy=%b required F 000 00000013 0",
                   mem_WE, mem_A, mem_W, rx_ready);
        end
      end
    end
    total++;
    if (wa_q.size() - base != 2) begin
      bad++;
      $display("FAIL good_write_count: got %0d required 2", wa_q.size() - base);
    end else begin
      total++;
      if (wa_q[base+1] !== 10'h1 || ww_q[base+1] !== 32'h0010_0093 || wwe_q[base+1] !== 4'hF) begin
        bad++;
        $display("FAIL good_second_write: A=%h W=%h WE=%h required 001 00100093 F",
                 wa_q[base+1], ww_q[base+1], wwe_q[base+1]);
      end
    end
    total++;
    if ({done, error, core_rst, busy} !== 4'b1000) begin
      bad++;
      $display("FAIL good_status: done/err/crst/busy=%b required 1000", {done, error, core_rst, busy});
    end
  endtask

  task automatic test_bad_chk();
    int base = wa_q.size();
    pulse_start();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL done_clear_on_start: got %b required 0", done);
    end
    tx_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h81};
    send_all(1'b0);
    total++;
    if (wa_q.size() - base != 2) begin
      bad++;
      $display("FAIL bad_chk_write_count: got %0d required 2", wa_q.size() - base);
    end
    total++;
    if ({done, error, core_rst, busy} !== 4'b0110) begin
      bad++;
      $display("FAIL bad_chk_status: done/err/crst/busy=%b required 0110", {done, error, core_rst, busy});
    end
  endtask

  task automatic test_zero();
    int base = wa_q.size();
    pulse_start();
    tx_q = '{8'h00, 8'h00, 8'h00};
    send_all(1'b0);
    total++;
    if ({done, error, core_rst} !== 3'b100 || wa_q.size() != base) begin
      bad++;
      $display("FAIL zero_good: done/err/crst=%b writes=%0d required 100 0",
               {done, error, core_rst}, wa_q.size() - base);
    end
    pulse_start();
    tx_q = '{8'h00, 8'h00, 8'h05};
    send_all(1'b0);
    total++;
    if ({done, error, core_rst} !== 3'b011) begin
      bad++;
      $display("FAIL zero_bad_chk: done/err/crst=%b required 011", {done, error, core_rst});
    end
  endtask

  task automatic test_oversize();
    int base = wa_q.size();
    pulse_start();
    tx_q = '{8'h01, 8'h04};
    send_all(1'b0);
    total++;
    if ({error, done, busy, rx_ready, core_rst} !== 5'b10001) begin
      bad++;
      $display("FAIL oversize_status: err/done/busy/rdy/crst=%b required 10001",
               {error, done, busy, rx_ready, core_rst});
    end
    repeat (3) @(negedge clk);
    total++;
    if (wa_q.size() != base) begin
      bad++;
      $display("FAIL oversize_no_write: got %0d writes required 0", wa_q.size() - base);
    end
  endtask

  task automatic test_full();
    int base = wa_q.size();
    int errs = 0;
    logic [7:0] chk = 8'h00;
    logic [31:0] exp_w;
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    for (int j = 0; j < 4096; j++) begin
      chk ^= img_byte(j);
      send_byte(img_byte(j), 1'b0);
    end
    send_byte(chk, 1'b0);
    total++;
    if (wa_q.size() - base != 1024) begin
      bad++;
      $display("FAIL full_write_count: got %0d required 1024", wa_q.size() - base);
    end else begin
      for (int k = 0; k < 1024; k++) begin
        exp_w = {img_byte(4*k+3), img_byte(4*k+2), img_byte(4*k+1), img_byte(4*k)};
        if (wa_q[base+k] !== 10'(k) || ww_q[base+k] !== exp_w) errs++;
      end
      total++;
      if (errs != 0) begin
        bad++;
        $display("FAIL full_contents: got %0d bad words required 0", errs);
      end
      total++;
      if (wa_q[base+1023] !== 10'h3FF) begin
        bad++;
        $display("FAIL full_last_addr: got %h required 3ff", wa_q[base+1023]);
      end
    end
    total++;
    if ({done, error, core_rst} !== 3'b100) begin
      bad++;
      $display("FAIL full_status: done/err/crst=%b required 100", {done, error, core_rst});
    end
  endtask

  task automatic test_random_gaps();
    int base = wa_q.size();
    pulse_start();
    tx_q = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
             8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0C};
    send_all(1'b1);
    total++;
    if (wa_q.size() - base != 3) begin
      bad++;
      $display("FAIL gaps_write_count: got %0d required 3", wa_q.size() - base);
    end else begin
      total++;
      if (ww_q[base] !== 32'h0403_0201 || ww_q[base+1] !== 32'h0807_0605 ||
          ww_q[base+2] !== 32'h0C0B_0A09 || wa_q[base+2] !== 10'h2) begin
        bad++;
        $display("FAIL gaps_words: got %h %h %h @%h required 04030201 08070605 0c0b0a09 @002",
                 ww_q[base], ww_q[base+1], ww_q[base+2], wa_q[base+2]);
      end
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL gaps_done: got %b required 1", done);
    end
    total++;
    if (rdy_viol != 0) begin
      bad++;
      $display("FAIL ready_vs_write: got %0d violating cycles required 0", rdy_viol);
    end
  endtask

  task automatic test_rst_mid();
    int base;
    pulse_start();
    tx_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
    send_all(1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({rx_ready, busy, core_rst, done, error} !== 5'b0 || {mem_WE, mem_A, mem_W} !== 46'h0) begin
      bad++;
      $display("FAIL async_reset: flags=%b WE=%h A=%h W=%h required all 0",
               {rx_ready, busy, core_rst, done, error}, mem_WE, mem_A, mem_W);
    end
    @(negedge clk);
    rst = 1'b0;
    base = wa_q.size();
    pulse_start();
    tx_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    send_all(1'b0);
    total++;
    if (done !== 1'b1 || wa_q.size() - base != 2) begin
      bad++;
      $display("FAIL reload_after_reset: done=%b writes=%0d required 1 2", done, wa_q.size() - base);
    end else begin
      total++;
      if (ww_q[base] !== 32'h0000_0013 || wa_q[base] !== 10'h0) begin
        bad++;
        $display("FAIL reload_first_word: A=%h W=%h required 000 00000013", wa_q[base], ww_q[base]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_chk();
    test_zero();
    test_oversize();
    test_full();
    test_random_gaps();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
